// File: rtl/cdc_pkg.sv
// Shared helpers for the asynchronous FIFO pointer blocks (write and read side).
// The Gray/binary conversions work on a 32-bit container; callers zero-extend
// their pointer in and truncate the result back to pointer width. Zero upper bits
// leave the low bits unchanged in both directions, so one function pair serves
// every FIFO depth.
package cdc_pkg;

    localparam int CDC_FN_W = 32;

    // Reset value for every pointer register (write/read binary, Gray, sync stages).
    localparam logic [CDC_FN_W-1:0] PTR_RST_VAL = '0;

    function automatic logic [CDC_FN_W-1:0] bin2gray(input logic [CDC_FN_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [CDC_FN_W-1:0] gray2bin(input logic [CDC_FN_W-1:0] g);
        logic [CDC_FN_W-1:0] b;
        b[CDC_FN_W-1] = g[CDC_FN_W-1];
        for (int i = CDC_FN_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a multi-bit Gray-coded bus crossing into i_clk.
// Only one bit of the source changes at a time, so per-bit synchronization is safe.
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q1;
    logic [WIDTH-1:0] r_q2;

    // First stage may go metastable; second stage gives it a full cycle to settle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q1 <= '0;
            r_q2 <= '0;
        end else begin
            r_q1 <= i_d;
            r_q2 <= r_q1;
        end
    end

    assign o_q = r_q2;

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full-flag generator of the asynchronous FIFO.
// Holds the binary write pointer, publishes its registered Gray form to the read
// domain, and derives full/level from the synchronized read Gray pointer.
// Full is computed from the *next* write pointer so that the write that fills the
// FIFO raises o_wfull on the same edge. It is pessimistic: the read pointer seen
// here lags the real one, so full can linger but never clears early.
import cdc_pkg::*;

module fifo_wptr_full #(
    parameter int ADDR_W = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_winc,
    input  logic [ADDR_W:0]   i_rgray_ptr,
    output logic              o_wen,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [ADDR_W:0]   o_wgray_ptr,
    output logic              o_wfull,
    output logic [ADDR_W:0]   o_wlevel
);

    localparam int PTR_W = ADDR_W + 1;

    logic [PTR_W-1:0] r_wbin;
    logic [PTR_W-1:0] r_wgray;
    logic             r_wfull;

    logic [PTR_W-1:0] w_rq2;
    logic [PTR_W-1:0] w_rbin;
    logic             w_accept;
    logic [PTR_W-1:0] w_wbin_next;
    logic [PTR_W-1:0] w_wgray_next;
    logic [PTR_W-1:0] w_full_cmp;
    logic             w_full_next;

    sync_2ff #(
        .WIDTH(PTR_W)
    ) u_rptr_sync (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_d    (i_rgray_ptr),
        .o_q    (w_rq2)
    );

    assign w_accept     = i_winc & ~r_wfull;
    assign w_wbin_next  = r_wbin + PTR_W'(w_accept);
    assign w_wgray_next = PTR_W'(bin2gray(CDC_FN_W'(w_wbin_next)));

    // Write pointer is exactly one lap ahead of the read pointer: in Gray code that
    // means the two MSBs differ and all lower bits match.
    assign w_full_cmp  = {~w_rq2[ADDR_W:ADDR_W-1], w_rq2[ADDR_W-2:0]};
    assign w_full_next = (w_wgray_next == w_full_cmp);

    assign w_rbin = PTR_W'(gray2bin(CDC_FN_W'(w_rq2)));

    // Pointer and full-flag registers; pointers hold whenever a request is refused.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wbin  <= PTR_W'(PTR_RST_VAL);
            r_wgray <= PTR_W'(PTR_RST_VAL);
            r_wfull <= 1'b0;
        end else begin
            r_wbin  <= w_wbin_next;
            r_wgray <= w_wgray_next;
            r_wfull <= w_full_next;
        end
    end

    assign o_wen       = w_accept;
    assign o_waddr     = r_wbin[ADDR_W-1:0];
    assign o_wgray_ptr = r_wgray;
    assign o_wfull     = r_wfull;
    // Modulo subtraction; lagging read pointer makes this an over-estimate.
    assign o_wlevel    = r_wbin - w_rbin;

endmodule
